// File: rtl/unidade_de_controle.sv
// Multicycle FETCH/DECODE/EXEC control FSM for the 8-bit accumulator CPU.
// Optional macro: CTRL_COND_BRANCH_EN enables JZ/JNZ; otherwise they decode as NOP.
module unidade_de_controle (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic [7:0] acOut,
  output logic       ld_ac,
  output logic       ac_src,
  output logic       pc_src,
  output logic       ld_pc,
  output logic       dm_we,
  output logic       halted,
  output logic [7:0] instr_count
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    HALT   = 2'd3
  } state_t;

  localparam logic [3:0] OP_LOAD  = 4'b0001;
  localparam logic [3:0] OP_STORE = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_OR    = 4'b0110;
  localparam logic [3:0] OP_XOR   = 4'b0111;
  localparam logic [3:0] OP_JMP   = 4'b1000;
  localparam logic [3:0] OP_JZ    = 4'b1001;
  localparam logic [3:0] OP_JNZ   = 4'b1010;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  state_t     state_q, state_d;
  logic [3:0] op_q;
  logic [7:0] count_q;
  logic       ac_zero;

`ifdef CTRL_COND_BRANCH_EN
  assign ac_zero = (acOut == 8'h00);
`else
  // Conditional branches are compiled out, so the accumulator is not observed.
  logic unused_acout;
  assign unused_acout = ^acOut;
  assign ac_zero      = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= FETCH;
      op_q    <= 4'b0000;
      count_q <= 8'h00;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) op_q <= opcode;
      if (state_q == EXEC) count_q <= count_q + 8'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    ld_ac   = 1'b0;
    ac_src  = 1'b0;
    pc_src  = 1'b0;
    ld_pc   = 1'b0;
    dm_we   = 1'b0;
    halted  = 1'b0;
    unique case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: state_d = EXEC;
      EXEC: begin
        if (op_q == OP_HALT) begin
          state_d = HALT;
        end else begin
          state_d = FETCH;
          ld_pc   = 1'b1;
          case (op_q)
            OP_LOAD: begin
              ld_ac  = 1'b1;
              ac_src = 1'b1;
            end
            OP_STORE: dm_we = 1'b1;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: ld_ac = 1'b1;
            OP_JMP: pc_src = 1'b1;
`ifdef CTRL_COND_BRANCH_EN
            OP_JZ:  pc_src = ac_zero;
            OP_JNZ: pc_src = !ac_zero;
`endif
            default: ;
          endcase
        end
      end
      HALT: halted = 1'b1;
      default: state_d = FETCH;
    endcase
  end

  assign instr_count = count_q;

endmodule

// File: doc/unidade_de_controle.md
# unidade_de_controle

Multicycle control FSM for the 8-bit accumulator CPU: it consumes the 4-bit `opcode` and accumulator value produced by the datapath and drives the datapath's control inputs (`ld_ac`, `ac_src`, `pc_src`) plus PC-load and data-memory write strobes. Every instruction takes exactly three clocks (FETCH, DECODE, EXEC). A HALT opcode parks the machine until reset. It sits beside the datapath in the CPU top level, between the datapath and the instruction/data memories.

## Interface
- No parameters; widths are fixed by the datapath (4-bit opcode, 8-bit accumulator).
- `clock`  in  1  single system clock, rising edge.
- `reset`  in  1  synchronous, active-low; sampled on rising `clock`.
- `opcode`  in  4  current instruction opcode (instruction bits [7:4]).
- `acOut`  in  8  accumulator value, used for the zero test.
- `ld_ac`  out  1  accumulator load enable.
- `ac_src`  out  1  accumulator input select: 0 = ALU result, 1 = data-memory read.
- `pc_src`  out  1  next-PC select: 0 = PC+1, 1 = instruction bits [3:0].
- `ld_pc`  out  1  PC load enable, one-cycle pulse per instruction.
- `dm_we`  out  1  data-memory write strobe (data = `acOut`, address = instruction bits [3:0]).
- `halted`  out  1  high while in HALT.
- `instr_count`  out  8  retired-instruction counter.

## Operation
- States: FETCH -> DECODE -> EXEC -> FETCH; EXEC -> HALT when the latched opcode is HALT; HALT is absorbing.
- FETCH: all strobes 0; the instruction bus settles from the current PC.
- DECODE: `opcode` is captured into an internal register `op_q`; all strobes 0.
- EXEC: strobes are decoded from `op_q` only (a changing `opcode` input in EXEC has no effect); `ld_pc` = 1 for every opcode except HALT.
- Opcode map (strobes asserted in EXEC; unlisted strobes 0):
  - 0000 NOP: `ld_pc`.
  - 0001 LOAD: `ld_ac`, `ac_src`=1.
  - 0010 STORE: `dm_we`.
  - 0011 ADD, 0100 SUB, 0101 AND, 0110 OR, 0111 XOR: `ld_ac`, `ac_src`=0.
  - 1000 JMP: `pc_src`=1.
  - 1001 JZ: `pc_src` = (`acOut` == 0).
  - 1010 JNZ: `pc_src` = (`acOut` != 0).
  - 1111 HALT: no strobes; the next state is HALT.
  - 1011-1110: treated as NOP.
- `instr_count` increments by 1 at the end of each EXEC cycle, HALT included. It wraps 255 -> 0.
- HALT: all strobes 0, `halted` = 1, `instr_count` frozen. Only `reset` leaves HALT.

## Timing
- Reset (`reset` = 0 at a rising edge): state = FETCH, `op_q` = 0000, `instr_count` = 0. All strobes and `halted` are 0 from that edge.
- Reset wins over every transition, including mid-EXEC: a strobe asserted in the EXEC cycle coincident with the reset edge does not repeat afterwards.
- Strobes are Moore-style, decoded from registered state and `op_q`, except that JZ/JNZ `pc_src` also depends on `acOut`. The datapath holds `acOut` stable through EXEC.
- Latency: 3 clocks per instruction. The first EXEC occurs on the 3rd clock after reset deasserts. A HALT reaches HALT state 3 clocks after its FETCH.
- Each strobe is high for exactly one clock per instruction; there are no back-to-back strobes.

## Configuration
- `CTRL_COND_BRANCH_EN` defined: JZ/JNZ behave as specified above.
- Not defined: opcodes 1001 and 1010 decode as NOP (`ld_pc` only, `pc_src` = 0), and `acOut` is unused.

## Test plan
- Reset then NOP stream: `halted` = 0 and all strobes 0 for 2 cycles. `ld_pc` pulses every 3rd clock. `instr_count` = 4 after 12 clocks.
- LOAD, ADD, STORE sequence: the LOAD EXEC shows `ld_ac` = 1, `ac_src` = 1. The ADD EXEC shows `ld_ac` = 1, `ac_src` = 0. The STORE EXEC shows `dm_we` = 1 and `ld_ac` = 0.
- JZ with `acOut` = 0x00 -> `pc_src` = 1. JZ with `acOut` = 0x05 -> `pc_src` = 0. JNZ gives the inverse. With the macro undefined, `pc_src` = 0 in all four cases.
- HALT: 3 clocks after its FETCH, `halted` = 1, `ld_pc` stays 0, and `instr_count` holds its value for 20 clocks. Reset then returns to FETCH with count 0.
- 256 NOPs -> `instr_count` wraps to 0x00.
- Reset asserted during the EXEC of a STORE: `dm_we` is 0 from the next edge, state = FETCH, `instr_count` = 0.
